dmem_responder: RTL and testbench

Multi-cycle, byte-addressed data-memory responder. It serves load/store requests issued by the CPU memory stage over a valid/ready request channel and a valid/ready response channel. It applies RV32I funct3 width and sign semantics and a configurable access latency, and it flags illegal accesses. This is the memory-side end of the memory-stage interface and lets the core be exercised against a non-ideal, stalling memory.

---
 rtl/dmem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Byte-addressed data memory with valid/ready request and
//               response channels, RV32I load/store semantics and a fixed
//               access latency.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 17,
    parameter int    LATENCY    = 2,
    parameter string MEM_INIT   = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int c_memBytes = 1 << ADDR_WIDTH;
    localparam int c_cntWidth = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_cntWidth-1:0] c_cntLoad =
        (LATENCY > 0) ? c_cntWidth'(LATENCY - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [c_cntWidth-1:0]   r_cnt;
    logic [c_cntWidth-1:0]   w_cntNext;

    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [2:0]              r_funct3;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic [7:0]              r_mem [0:c_memBytes-1];

    logic                    w_accept;
    logic                    w_enterResp;
    logic                    w_effWe;
    logic [DATA_WIDTH-1:0]   w_effAddr;
    logic [2:0]              w_effFunct3;
    logic [DATA_WIDTH-1:0]   w_effWdata;
    logic                    w_outOfRange;
    logic                    w_fmtErr;
    logic                    w_err;
    logic [ADDR_WIDTH-1:0]   w_idx0;
    logic [ADDR_WIDTH-1:0]   w_idx1;
    logic [ADDR_WIDTH-1:0]   w_idx2;
    logic [ADDR_WIDTH-1:0]   w_idx3;
    logic [7:0]              w_b0;
    logic [7:0]              w_b1;
    logic [7:0]              w_b2;
    logic [7:0]              w_b3;
    logic [DATA_WIDTH-1:0]   w_loadData;

    assign req_ready  = (r_state == IDLE) && !rst;
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign w_accept   = req_valid && req_ready;

    // With zero latency RESP is entered on the accepting edge, so the live
    // request fields stand in for the not-yet-captured ones.
    assign w_enterResp = !rst && (((r_state == IDLE) && req_valid && (LATENCY == 0))
                                  || ((r_state == WAIT) && (r_cnt == '0)));
    assign w_effWe     = (r_state == IDLE) ? req_we     : r_we;
    assign w_effAddr   = (r_state == IDLE) ? req_addr   : r_addr;
    assign w_effFunct3 = (r_state == IDLE) ? req_funct3 : r_funct3;
    assign w_effWdata  = (r_state == IDLE) ? req_wdata  : r_wdata;

    generate
        if (ADDR_WIDTH < DATA_WIDTH) begin : g_addrCheck
            assign w_outOfRange = |w_effAddr[DATA_WIDTH-1:ADDR_WIDTH];
        end else begin : g_noAddrCheck
            assign w_outOfRange = 1'b0;
        end
    endgenerate

    assign w_idx0 = w_effAddr[ADDR_WIDTH-1:0];
    assign w_idx1 = w_idx0 + ADDR_WIDTH'(1);
    assign w_idx2 = w_idx0 + ADDR_WIDTH'(2);
    assign w_idx3 = w_idx0 + ADDR_WIDTH'(3);
    assign w_b0   = r_mem[w_idx0];
    assign w_b1   = r_mem[w_idx1];
    assign w_b2   = r_mem[w_idx2];
    assign w_b3   = r_mem[w_idx3];

    always_comb begin
        w_fmtErr = 1'b0;
        case (w_effFunct3)
            3'b000:  w_fmtErr = 1'b0;
            3'b001:  w_fmtErr = w_effAddr[0];
            3'b010:  w_fmtErr = |w_effAddr[1:0];
            3'b100:  w_fmtErr = w_effWe;
            3'b101:  w_fmtErr = w_effWe | w_effAddr[0];
            default: w_fmtErr = 1'b1;
        endcase
        w_err = w_fmtErr | w_outOfRange;
    end

    always_comb begin
        w_loadData = '0;
        if (!w_err && !w_effWe) begin
            case (w_effFunct3)
                3'b000:  w_loadData = {{(DATA_WIDTH-8){w_b0[7]}}, w_b0};
                3'b001:  w_loadData = {{(DATA_WIDTH-16){w_b1[7]}}, w_b1, w_b0};
                3'b010:  w_loadData = DATA_WIDTH'({w_b3, w_b2, w_b1, w_b0});
                3'b100:  w_loadData = {{(DATA_WIDTH-8){1'b0}}, w_b0};
                3'b101:  w_loadData = {{(DATA_WIDTH-16){1'b0}}, w_b1, w_b0};
                default: w_loadData = '0;
            endcase
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        w_nextState = RESP;
                    end else begin
                        w_nextState = WAIT;
                        w_cntNext   = c_cntLoad;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_nextState = RESP;
                end else begin
                    w_cntNext = r_cnt - c_cntWidth'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_cntNext;
            if (w_accept) begin
                r_we     <= req_we;
                r_addr   <= req_addr;
                r_funct3 <= req_funct3;
                r_wdata  <= req_wdata;
            end
            if (w_enterResp) begin
                r_rdata <= w_loadData;
                r_err   <= w_err;
            end
        end
    end

    // Memory contents survive reset; w_enterResp already excludes reset.
    always_ff @(posedge clk) begin
        if (w_enterResp && w_effWe && !w_err) begin
            r_mem[w_idx0] <= w_effWdata[7:0];
            if (w_effFunct3[1:0] != 2'b00) begin
                r_mem[w_idx1] <= w_effWdata[15:8];
            end
            if (w_effFunct3[1:0] == 2'b10) begin
                r_mem[w_idx2] <= w_effWdata[23:16];
                r_mem[w_idx3] <= w_effWdata[31:24];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder at LATENCY 2 and 0.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid2 = 1'b0;
    logic        reqValid0 = 1'b0;
    logic        reqWe = 1'b0;
    logic [31:0] reqAddr = '0;
    logic [2:0]  reqFunct3 = '0;
    logic [31:0] reqWdata = '0;
    logic        respReady = 1'b1;

    logic        ready2, valid2, err2;
    logic [31:0] rdata2;
    logic        ready0, valid0, err0;
    logic [31:0] rdata0;

    logic        useZero = 1'b0;
    int          expLat = 3;
    logic        curReady, curValid, curErr;
    logic [31:0] curRdata;

    int          nCompared = 0;
    int          nMismatched = 0;

    logic [32:0] expQ[$];
    string       nameQ[$];

    assign curReady = useZero ? ready0 : ready2;
    assign curValid = useZero ? valid0 : valid2;
    assign curErr   = useZero ? err0   : err2;
    assign curRdata = useZero ? rdata0 : rdata2;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(2), .MEM_INIT("")) dut2 (
        .clk(clk), .rst(rst), .req_valid(reqValid2), .req_ready(ready2),
        .req_we(reqWe), .req_addr(reqAddr), .req_funct3(reqFunct3), .req_wdata(reqWdata),
        .resp_valid(valid2), .resp_ready(respReady), .resp_rdata(rdata2), .resp_err(err2)
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(0), .MEM_INIT("")) dut0 (
        .clk(clk), .rst(rst), .req_valid(reqValid0), .req_ready(ready0),
        .req_we(reqWe), .req_addr(reqAddr), .req_funct3(reqFunct3), .req_wdata(reqWdata),
        .resp_valid(valid0), .resp_ready(respReady), .resp_rdata(rdata0), .resp_err(err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed on the edge after a negedge that sees valid && ready.
    always @(negedge clk) begin
        if (curValid && respReady && !rst) begin
            if (expQ.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                string       nm;
                e  = expQ.pop_front();
                nm = nameQ.pop_front();
                chk({nm, "_rdata"}, curRdata, e[32:1]);
                chk({nm, "_err"}, {31'd0, curErr}, {31'd0, e[0]});
            end
        end
    end

    task automatic setValid(input logic v);
        if (useZero) reqValid0 = v;
        else         reqValid2 = v;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd);
        int n;
        reqWe = we; reqAddr = addr; reqFunct3 = f3; reqWdata = wd;
        setValid(1'b1);
        n = 0;
        while (!curReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input string name, input logic we, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] wd,
                         input logic [31:0] expData, input logic expErr);
        int   n;
        logic busyBad;
        drive(we, addr, f3, wd);
        expQ.push_back({expData, expErr});
        nameQ.push_back(name);
        @(posedge clk);
        #1 setValid(1'b0);
        n = 0;
        busyBad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (curReady) busyBad = 1'b1;
        end while (!curValid && n < 50);
        chk({name, "_latency"}, n, expLat);
        chk({name, "_busy"}, {31'd0, busyBad}, 32'd0);
        @(negedge clk);
        chk({name, "_single"}, {31'd0, curValid}, 32'd0);
    endtask

    // Accept a store, then reset on the k-th edge after acceptance.
    task automatic abortStore(input string name, input int k, input logic [31:0] addr,
                              input logic [31:0] wd);
        logic sawValid;
        drive(1'b1, addr, 3'b010, wd);
        @(posedge clk);
        #1 setValid(1'b0);
        repeat (k - 1) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sawValid = 1'b0;
        @(negedge clk);
        chk({name, "_ready_back"}, {31'd0, curReady}, 32'd1);
        repeat (4) begin
            if (curValid) sawValid = 1'b1;
            @(negedge clk);
        end
        chk({name, "_no_resp"}, {31'd0, sawValid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic holdBad;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, ready2}, 32'd0);
        chk("rst_resp_valid", {31'd0, valid2}, 32'd0);
        chk("rst_rdata", rdata2, 32'd0);
        chk("rst_err", {31'd0, err2}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue("sw_init200", 1'b1, 32'h200, 3'b010, 32'h0, 32'h0, 1'b0);
        issue("sw_100", 1'b1, 32'h100, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
        issue("lw_100", 1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);

        issue("lb_103", 1'b0, 32'h103, 3'b000, 32'h0, 32'hFFFFFFDE, 1'b0);
        issue("lbu_103", 1'b0, 32'h103, 3'b100, 32'h0, 32'h000000DE, 1'b0);
        issue("lh_102", 1'b0, 32'h102, 3'b001, 32'h0, 32'hFFFFDEAD, 1'b0);
        issue("lhu_102", 1'b0, 32'h102, 3'b101, 32'h0, 32'h0000DEAD, 1'b0);
        issue("lb_100", 1'b0, 32'h100, 3'b000, 32'h0, 32'hFFFFFFEF, 1'b0);

        issue("sb_101", 1'b1, 32'h101, 3'b000, 32'h12345677, 32'h0, 1'b0);
        issue("lw_after_sb", 1'b0, 32'h100, 3'b010, 32'h0, 32'hDEAD77EF, 1'b0);
        issue("sh_102", 1'b1, 32'h102, 3'b001, 32'hAAAA5555, 32'h0, 1'b0);
        issue("lw_after_sh", 1'b0, 32'h100, 3'b010, 32'h0, 32'h555577EF, 1'b0);

        issue("lw_misalign", 1'b0, 32'h102, 3'b010, 32'h0, 32'h0, 1'b1);
        issue("sh_misalign", 1'b1, 32'h101, 3'b001, 32'hFFFF, 32'h0, 1'b1);
        issue("lw_after_bad_sh", 1'b0, 32'h100, 3'b010, 32'h0, 32'h555577EF, 1'b0);
        issue("lw_range", 1'b0, 32'h00020000, 3'b010, 32'h0, 32'h0, 1'b1);
        issue("ld_f3_011", 1'b0, 32'h100, 3'b011, 32'h0, 32'h0, 1'b1);
        issue("st_f3_100", 1'b1, 32'h100, 3'b100, 32'h0, 32'h0, 1'b1);
        issue("lw_after_bad_st", 1'b0, 32'h100, 3'b010, 32'h0, 32'h555577EF, 1'b0);

        // Backpressure with a second request waiting.
        respReady = 1'b0;
        drive(1'b0, 32'h100, 3'b010, 32'h0);
        expQ.push_back({32'h555577EF, 1'b0});
        nameQ.push_back("bp_lw_100");
        @(posedge clk);
        #1 reqAddr = 32'h200;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid2 && n < 50);
        chk("bp_latency", n, 3);
        holdBad = 1'b0;
        repeat (5) begin
            if (!valid2 || rdata2 !== 32'h555577EF || ready2) holdBad = 1'b1;
            @(negedge clk);
        end
        chk("bp_hold", {31'd0, holdBad}, 32'd0);
        @(posedge clk);
        #1 respReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", {31'd0, ready2}, 32'd1);
        chk("bp_idle_valid", {31'd0, valid2}, 32'd0);
        expQ.push_back({32'h0, 1'b0});
        nameQ.push_back("bp_pending_lw_200");
        @(posedge clk);
        #1 reqValid2 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid2 && n < 50);
        chk("bp_pending_latency", n, 3);
        @(negedge clk);

        abortStore("rst_wait", 1, 32'h200, 32'h11111111);
        issue("lw_200_after_rst", 1'b0, 32'h200, 3'b010, 32'h0, 32'h0, 1'b0);
        abortStore("rst_enter", 2, 32'h200, 32'h22222222);
        issue("lw_200_after_rst2", 1'b0, 32'h200, 3'b010, 32'h0, 32'h0, 1'b0);

        useZero = 1'b1;
        expLat  = 1;
        issue("z_sw_200", 1'b1, 32'h200, 3'b010, 32'h11111111, 32'h0, 1'b0);
        issue("z_lw_200", 1'b0, 32'h200, 3'b010, 32'h0, 32'h11111111, 1'b0);
        issue("z_lh_misalign", 1'b0, 32'h201, 3'b001, 32'h0, 32'h0, 1'b1);

        // Reset while holding a response at zero latency.
        respReady = 1'b0;
        drive(1'b1, 32'h300, 3'b010, 32'hCAFEF00D);
        @(posedge clk);
        #1 reqValid0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("z_resp_before_rst", {31'd0, valid0}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        respReady = 1'b1;
        @(negedge clk);
        chk("z_resp_dropped", {31'd0, valid0}, 32'd0);
        issue("z_lw_300", 1'b0, 32'h300, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drain", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
